oam_dma: RTL and testbench

Sprite DMA controller that sits between the CPU core and the system memory bus. When the CPU writes a page number to the DMA register at `$4014`, the controller stalls the CPU and takes over the bus. It then copies 256 bytes from CPU page `$XX00–$XXFF` into the PPU OAM data port at `$2004` as alternating read/write cycles, and hands the bus back. Outside a transfer it is a transparent pass-through of the CPU bus signals.

---
 rtl/oam_dma.sv | 128 ++++++++++++
 tb/tb_oam_dma.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
// oam_dma - sprite DMA controller between the CPU core and the system bus.
//
// A CPU write to DMA_REG_ADDR latches a page number, halts the CPU and copies
// the 256 bytes at {page,8'h00}..{page,8'hFF} into the OAM data port, one
// read cycle followed by one write cycle per byte.  Outside a transfer the
// CPU bus passes straight through to the memory system.
//
// Ports:
//   clk_ph1      - system clock, rising edge
//   rst          - asynchronous reset, active low
//   cpu_addr     - CPU address
//   cpu_data_out - CPU write data
//   cpu_R_nW     - CPU read/not-write
//   Data_bus_in  - read data from memory (combinational read)
//   Addr_bus     - address to memory
//   Data_bus_out - write data to memory
//   R_nW         - read/not-write to memory
//   cpu_halt     - CPU must hold all state this cycle
//   dma_active   - DMA owns the bus
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | pass-through, waiting for a CPU write to DMA_REG_ADDR
// HALT  | first dummy cycle while the CPU stalls
// ALIGN | extra dummy cycle when HALT landed on an odd cycle
// READ  | read {page,idx} into data_buf
// WRITE | write data_buf to OAM_DATA_ADDR, advance idx or finish

module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clk_ph1,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_R_nW,
  input  logic [7:0]  Data_bus_in,
  output logic [15:0] Addr_bus,
  output logic [7:0]  Data_bus_out,
  output logic        R_nW,
  output logic        cpu_halt,
  output logic        dma_active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t      state, state_next;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  data_buf;
  logic        odd;
  logic        trigger;
  logic [15:0] dma_addr;
  logic        dma_rnw;

  // CPU reads of the DMA register never start a transfer.
  assign trigger = (state == S_IDLE) && (cpu_addr == DMA_REG_ADDR) && !cpu_R_nW;

  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    dma_addr   = cpu_addr;
    dma_rnw    = 1'b1;
    case (state)
      S_IDLE: begin
        if (trigger) state_next = S_HALT;
      end
      S_HALT: begin
        state_next = odd ? S_ALIGN : S_READ;
      end
      S_ALIGN: begin
        state_next = S_READ;
      end
      S_READ: begin
        // idx never carries into page: reads stay inside the selected page.
        dma_addr   = {page, idx};
        state_next = S_WRITE;
      end
      S_WRITE: begin
        dma_addr   = OAM_DATA_ADDR;
        dma_rnw    = 1'b0;
        state_next = (idx == 8'hFF) ? S_IDLE : S_READ;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_ph1 or negedge rst) begin
    if (!rst) begin
      page     <= 8'h00;
      idx      <= 8'h00;
      data_buf <= 8'h00;
      odd      <= 1'b0;
    end else begin
      odd <= ~odd;
      if (trigger) begin
        page <= cpu_data_out;
        idx  <= 8'h00;
      end
      if (state == S_READ) data_buf <= Data_bus_in;
      if (state == S_WRITE && idx != 8'hFF) idx <= idx + 8'd1;
    end
  end

  assign dma_active = (state != S_IDLE);
  assign cpu_halt   = dma_active;

  assign Addr_bus     = dma_active ? dma_addr : cpu_addr;
  assign Data_bus_out = dma_active ? data_buf : cpu_data_out;
  assign R_nW         = dma_active ? dma_rnw  : cpu_R_nW;

endmodule

// File: tb/tb_oam_dma.sv
module tb_oam_dma;

  logic        clk_ph1 = 1'b0;
  logic        rst     = 1'b0;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data_out;
  logic        cpu_R_nW;
  logic [7:0]  Data_bus_in;
  logic [15:0] Addr_bus;
  logic [7:0]  Data_bus_out;
  logic        R_nW;
  logic        cpu_halt;
  logic        dma_active;

  oam_dma dut (
    .clk_ph1      (clk_ph1),
    .rst          (rst),
    .cpu_addr     (cpu_addr),
    .cpu_data_out (cpu_data_out),
    .cpu_R_nW     (cpu_R_nW),
    .Data_bus_in  (Data_bus_in),
    .Addr_bus     (Addr_bus),
    .Data_bus_out (Data_bus_out),
    .R_nW         (R_nW),
    .cpu_halt     (cpu_halt),
    .dma_active   (dma_active)
  );

  always #5 clk_ph1 = ~clk_ph1;

  // Memory model: combinational read, data = low address byte ^ 5A.
  assign Data_bus_in = Addr_bus[7:0] ^ 8'h5A;

  // Reference cycle parity: cleared by reset, toggles every rising edge.
  logic tb_odd;
  always @(posedge clk_ph1 or negedge rst) begin
    if (!rst) tb_odd <= 1'b0;
    else      tb_odd <= ~tb_odd;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [15:0] log_addr[$];
  logic        log_rnw[$];
  logic [7:0]  log_data[$];

  task automatic cpu_idle();
    cpu_addr     = 16'h8000;
    cpu_R_nW     = 1'b1;
    cpu_data_out = 8'h00;
  endtask

  task automatic run_dma(input logic [7:0] pg, input bit want_odd, input string nm);
    int n;
    int guard;
    int d;
    int zero_hits;
    logic [15:0] exp_addr;
    logic [7:0]  kb;
    guard = 0;
    @(negedge clk_ph1);
    // odd in HALT is the inverse of odd during the trigger cycle.
    while (tb_odd == want_odd && guard < 10) begin
      @(negedge clk_ph1);
      guard++;
    end
    cpu_addr     = 16'h4014;
    cpu_R_nW     = 1'b0;
    cpu_data_out = pg;
    @(negedge clk_ph1);
    cpu_idle();
    log_addr.delete();
    log_rnw.delete();
    log_data.delete();
    n = 0;
    while (cpu_halt && n < 600) begin
      log_addr.push_back(Addr_bus);
      log_rnw.push_back(R_nW);
      log_data.push_back(Data_bus_out);
      n++;
      @(negedge clk_ph1);
    end
    check({nm, " halted_cycles"}, n, want_odd ? 514 : 513);
    check({nm, " handback_active"}, dma_active, 1'b0);
    check({nm, " handback_addr"}, Addr_bus, 16'h8000);
    check({nm, " handback_rnw"}, R_nW, 1'b1);
    d = want_odd ? 2 : 1;
    for (int i = 0; i < d && i < log_rnw.size(); i++)
      check({nm, " dummy_rnw"}, log_rnw[i], 1'b1);
    zero_hits = 0;
    foreach (log_addr[i]) if (log_addr[i] == 16'h0000) zero_hits++;
    check({nm, " page0_access"}, zero_hits, 0);
    if (log_addr.size() == 512 + d) begin
      for (int k = 0; k < 256; k++) begin
        kb = k[7:0];
        exp_addr = {pg, kb};
        check($sformatf("%s rd_addr[%0d]", nm, k), log_addr[d + 2*k], exp_addr);
        check($sformatf("%s rd_rnw[%0d]", nm, k), log_rnw[d + 2*k], 1'b1);
        check($sformatf("%s wr_addr[%0d]", nm, k), log_addr[d + 2*k + 1], 16'h2004);
        check($sformatf("%s wr_rnw[%0d]", nm, k), log_rnw[d + 2*k + 1], 1'b0);
        check($sformatf("%s wr_data[%0d]", nm, k), log_data[d + 2*k + 1], kb ^ 8'h5A);
      end
      check({nm, " last_read"}, log_addr[d + 510], {pg, 8'hFF});
      check({nm, " after_last_read"}, log_addr[d + 511], 16'h2004);
    end else begin
      check({nm, " log_size"}, log_addr.size(), 512 + d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int act_hits;
    int oam_writes;

    // Reset state and pass-through while in reset.
    cpu_addr     = 16'h0102;
    cpu_R_nW     = 1'b1;
    cpu_data_out = 8'h33;
    #1;
    check("rst_addr", Addr_bus, 16'h0102);
    check("rst_rnw", R_nW, 1'b1);
    check("rst_halt", cpu_halt, 1'b0);
    check("rst_active", dma_active, 1'b0);
    repeat (3) @(negedge clk_ph1);
    rst = 1'b1;
    @(negedge clk_ph1);
    check("idle_addr", Addr_bus, 16'h0102);
    check("idle_rnw", R_nW, 1'b1);
    check("idle_halt", cpu_halt, 1'b0);
    check("idle_active", dma_active, 1'b0);
    check("idle_data", Data_bus_out, 8'h33);

    // Non-trigger accesses.
    act_hits = 0;
    cpu_addr = 16'h4014; cpu_R_nW = 1'b1; cpu_data_out = 8'h02;
    @(negedge clk_ph1);
    if (dma_active) act_hits++;
    cpu_addr = 16'h4015; cpu_R_nW = 1'b0; cpu_data_out = 8'hC3;
    @(negedge clk_ph1);
    if (dma_active) act_hits++;
    check("wr4015_addr", Addr_bus, 16'h4015);
    check("wr4015_rnw", R_nW, 1'b0);
    check("wr4015_data", Data_bus_out, 8'hC3);
    cpu_idle();
    repeat (4) begin
      @(negedge clk_ph1);
      if (dma_active) act_hits++;
    end
    check("non_trigger_active", act_hits, 0);

    run_dma(8'h02, 1'b0, "even");
    run_dma(8'h02, 1'b1, "odd");
    run_dma(8'hFF, 1'b0, "pageFF");

    // Reset in the middle of a transfer.
    @(negedge clk_ph1);
    cpu_addr = 16'h4014; cpu_R_nW = 1'b0; cpu_data_out = 8'h03;
    @(negedge clk_ph1);
    cpu_idle();
    repeat (100) @(negedge clk_ph1);
    check("mid_active_before", dma_active, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_halt", cpu_halt, 1'b0);
    check("mid_rst_active", dma_active, 1'b0);
    check("mid_rst_addr", Addr_bus, 16'h8000);
    check("mid_rst_rnw", R_nW, 1'b1);
    @(negedge clk_ph1);
    rst = 1'b1;
    oam_writes = 0;
    act_hits   = 0;
    repeat (600) begin
      @(negedge clk_ph1);
      if (dma_active) act_hits++;
      if (!R_nW && Addr_bus == 16'h2004) oam_writes++;
    end
    check("post_rst_oam_writes", oam_writes, 0);
    check("post_rst_active", act_hits, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
